// File: rtl/cam_burst_writer.sv
// rtl/cam_burst_writer.sv - camera pixel FIFO feeding fixed-length SDRAM write bursts
// Frame restarts flush the FIFO only from IDLE so an in-flight burst always completes.
module cam_burst_writer #(
   parameter int unsigned BURST_LEN   = 8,
   parameter int unsigned FIFO_DEPTH  = 32,
   parameter int unsigned FRAME_WORDS = 307200,
   parameter logic [23:0] BASE_ADDR   = 24'h000000
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        frame_start,
   input  logic        pix_wr_en,
   input  logic [15:0] pix_data,
   output logic        wr_req,
   output logic [23:0] wr_addr,
   input  logic        wr_ack,
   input  logic        wr_data_rd,
   output logic [15:0] wr_data,
   output logic        frame_done,
   output logic        overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(BURST_LEN);
   localparam logic [AW:0]   LEN_CNT   = (AW+1)'(BURST_LEN);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
   localparam logic [23:0]   LEN_ADDR  = 24'(BURST_LEN);
   localparam logic [23:0]   END_ADDR  = BASE_ADDR + 24'(FRAME_WORDS);

   typedef enum logic [1:0] {IDLE, REQ, BURST} state_t;

   state_t        state;
   logic [15:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [BW-1:0] beat;
   logic [23:0]   cur_addr;
   logic          pending;
   logic          full;
   logic          flush;
   logic          pop;
   logic          push;
   logic          last_beat;

   // count never exceeds FIFO_DEPTH, so its top bit alone marks full
   assign full      = count[AW];
   assign flush     = (state == IDLE) && (frame_start || pending);
   assign pop       = (state == BURST) && wr_data_rd;
   assign push      = pix_wr_en && (!full || pop) && !flush;
   assign last_beat = pop && (beat == LAST_BEAT);
   assign wr_data   = mem[rd_ptr];
   assign wr_addr   = cur_addr;

   always_ff @(posedge sys_clk) begin
      if (push) mem[wr_ptr] <= pix_data;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         beat       <= '0;
         cur_addr   <= BASE_ADDR;
         pending    <= 1'b0;
         wr_req     <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         if (pix_wr_en && full && !pop && !flush) overflow <= 1'b1;
         if (frame_start && state != IDLE) pending <= 1'b1;

         case (state)
            IDLE: begin
               if (flush) begin
                  // later assignments override the pointer/count updates above
                  wr_ptr   <= '0;
                  rd_ptr   <= '0;
                  count    <= '0;
                  cur_addr <= BASE_ADDR;
                  pending  <= 1'b0;
               end else if (count >= LEN_CNT) begin
                  state  <= REQ;
                  wr_req <= 1'b1;
               end
            end
            REQ: begin
               if (wr_ack) begin
                  state  <= BURST;
                  wr_req <= 1'b0;
                  beat   <= '0;
               end
            end
            BURST: begin
               if (pop) beat <= beat + 1'b1;
               if (last_beat) begin
                  state <= IDLE;
                  if (cur_addr + LEN_ADDR == END_ADDR) begin
                     cur_addr   <= BASE_ADDR;
                     frame_done <= 1'b1;
                  end else begin
                     cur_addr <= cur_addr + LEN_ADDR;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               wr_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
